// File: rtl/rtc_bus_pkg.sv
// Shared types, timing defaults and pin decode for the RTC bus controller.
// Optional readback-verify states are compiled in with RTC_VERIFY_EN.
package rtc_bus_pkg;

  localparam int DEF_T_SETUP  = 2;
  localparam int DEF_T_STROBE = 8;
  localparam int DEF_T_HOLD   = 2;
  localparam int DEF_T_GAP    = 4;

  localparam logic OP_WR = 1'b1;
  localparam logic OP_RD = 1'b0;

  typedef enum logic [3:0] {
    IDLE,
    A_SETUP,
    A_STROBE,
    A_HOLD,
    GAP,
    D_SETUP,
    D_STROBE,
    D_HOLD,
`ifdef RTC_VERIFY_EN
    V_A_SETUP,
    V_A_STROBE,
    V_A_HOLD,
    V_GAP,
    V_D_SETUP,
    V_D_STROBE,
    V_D_HOLD,
`endif
    DONE
  } state_t;

  typedef struct packed {
    logic       a_d;
    logic       cs;
    logic       rd;
    logic       wr;
    logic       oe;
    logic [7:0] dout;
  } pins_t;

  localparam pins_t PINS_IDLE = '{a_d: 1'b1, cs: 1'b1, rd: 1'b1, wr: 1'b1, oe: 1'b0, dout: 8'h00};

  // Pin levels for a state; the address is always written with WR, even for reads.
  function automatic pins_t phase_pins(input state_t s, input logic op,
                                       input logic [7:0] a, input logic [7:0] d);
    pins_t p;
    p = PINS_IDLE;
    case (s)
      A_SETUP, A_HOLD: begin
        p.a_d = 1'b0; p.oe = 1'b1; p.dout = a;
      end
      A_STROBE: begin
        p.a_d = 1'b0; p.oe = 1'b1; p.dout = a; p.cs = 1'b0; p.wr = 1'b0;
      end
      D_SETUP, D_HOLD: begin
        if (op == OP_WR) begin
          p.oe = 1'b1; p.dout = d;
        end else begin
          p.oe = 1'b0;
        end
      end
      D_STROBE: begin
        p.cs = 1'b0;
        if (op == OP_WR) begin
          p.wr = 1'b0; p.oe = 1'b1; p.dout = d;
        end else begin
          p.rd = 1'b0;
        end
      end
`ifdef RTC_VERIFY_EN
      V_A_SETUP, V_A_HOLD: begin
        p.a_d = 1'b0; p.oe = 1'b1; p.dout = a;
      end
      V_A_STROBE: begin
        p.a_d = 1'b0; p.oe = 1'b1; p.dout = a; p.cs = 1'b0; p.wr = 1'b0;
      end
      V_D_STROBE: begin
        p.cs = 1'b0; p.rd = 1'b0;
      end
`endif
      default: p = PINS_IDLE;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/rtc_bus_ctrl_if.sv
// Request side and RTC pin side of the RTC bus controller.
interface rtc_bus_ctrl_if;
  logic       req_wr;
  logic       req_rd;
  logic [7:0] addr;
  logic [7:0] wdata;
  logic [7:0] bus_in;
  logic [7:0] bus_out;
  logic       bus_oe;
  logic       A_D;
  logic       CS;
  logic       RD;
  logic       WR;
  logic       busy;
  logic       done;
  logic [7:0] rdata;
  logic       err;

  modport master (
    output req_wr, req_rd, addr, wdata, bus_in,
    input  bus_out, bus_oe, A_D, CS, RD, WR, busy, done, rdata, err
  );

  modport slave (
    input  req_wr, req_rd, addr, wdata, bus_in,
    output bus_out, bus_oe, A_D, CS, RD, WR, busy, done, rdata, err
  );
endinterface

// File: rtl/rtc_phase_timer.sv
// Loadable down-counter shared by all bus phases; zero marks the last phase cycle.
module rtc_phase_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] count_r;

  // Count down to zero and park there until reloaded.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_r <= '0;
    end else if (load) begin
      count_r <= load_val;
    end else if (count_r != '0) begin
      count_r <= count_r - 1'b1;
    end else begin
      count_r <= count_r;
    end
  end

  assign zero = (count_r == '0);

endmodule

// File: rtl/rtc_bus_ctrl.sv
// Address/data-phase transaction engine for the RTC multiplexed bus.
// Define RTC_VERIFY_EN to append an automatic readback check to every write.
module rtc_bus_ctrl
  import rtc_bus_pkg::*;
#(
  parameter int T_SETUP  = DEF_T_SETUP,
  parameter int T_STROBE = DEF_T_STROBE,
  parameter int T_HOLD   = DEF_T_HOLD,
  parameter int T_GAP    = DEF_T_GAP
) (
  input logic           clk,
  input logic           reset,
  rtc_bus_ctrl_if.slave bus
);

  state_t     state_r, state_nxt_s;
  logic       op_r, op_nxt_s;
  logic [7:0] addr_r, addr_nxt_s;
  logic [7:0] wdata_r, wdata_nxt_s;
  logic       accept_s, load_s, zero_s, capture_s;
  logic [7:0] load_val_s;
  pins_t      pins_r;
  logic       busy_r, done_r, err_r;
  logic [7:0] rdata_r;

  function automatic logic [7:0] phase_len(input state_t s);
    case (s)
      A_SETUP, D_SETUP:   return 8'(T_SETUP);
      A_STROBE, D_STROBE: return 8'(T_STROBE);
      A_HOLD, D_HOLD:     return 8'(T_HOLD);
      GAP:                return 8'(T_GAP);
`ifdef RTC_VERIFY_EN
      V_A_SETUP, V_D_SETUP:   return 8'(T_SETUP);
      V_A_STROBE, V_D_STROBE: return 8'(T_STROBE);
      V_A_HOLD, V_D_HOLD:     return 8'(T_HOLD);
      V_GAP:                  return 8'(T_GAP);
`endif
      default:            return 8'd1;
    endcase
  endfunction

  function automatic state_t next_phase(input state_t s);
    case (s)
      A_SETUP:    return A_STROBE;
      A_STROBE:   return A_HOLD;
      A_HOLD:     return GAP;
      GAP:        return D_SETUP;
      D_SETUP:    return D_STROBE;
      D_STROBE:   return D_HOLD;
`ifdef RTC_VERIFY_EN
      V_A_SETUP:  return V_A_STROBE;
      V_A_STROBE: return V_A_HOLD;
      V_A_HOLD:   return V_GAP;
      V_GAP:      return V_D_SETUP;
      V_D_SETUP:  return V_D_STROBE;
      V_D_STROBE: return V_D_HOLD;
      V_D_HOLD:   return DONE;
`endif
      default:    return IDLE;
    endcase
  endfunction

  rtc_phase_timer #(.W(8)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (load_s),
    .load_val (load_val_s),
    .zero     (zero_s)
  );

  // Request acceptance, next state and phase-timer reload.
  always_comb begin
    accept_s = (state_r == IDLE) && (bus.req_wr || bus.req_rd);
    if (accept_s) begin
      op_nxt_s    = bus.req_wr ? OP_WR : OP_RD;
      addr_nxt_s  = bus.addr;
      wdata_nxt_s = bus.wdata;
    end else begin
      op_nxt_s    = op_r;
      addr_nxt_s  = addr_r;
      wdata_nxt_s = wdata_r;
    end

    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) state_nxt_s = A_SETUP;
        else          state_nxt_s = IDLE;
      end
      D_HOLD: begin
        if (zero_s) begin
`ifdef RTC_VERIFY_EN
          if (op_r == OP_WR) state_nxt_s = V_A_SETUP;
          else               state_nxt_s = DONE;
`else
          state_nxt_s = DONE;
`endif
        end else begin
          state_nxt_s = state_r;
        end
      end
      DONE:    state_nxt_s = IDLE;
      default: begin
        if (zero_s) state_nxt_s = next_phase(state_r);
        else        state_nxt_s = state_r;
      end
    endcase

    load_s     = (state_nxt_s != state_r);
    load_val_s = phase_len(state_nxt_s) - 8'd1;

    // Sample on the last strobe cycle, while RD is still low.
    capture_s = zero_s && (state_r == D_STROBE) && (op_r == OP_RD);
`ifdef RTC_VERIFY_EN
    capture_s = capture_s || (zero_s && (state_r == V_D_STROBE));
`endif
  end

  // State, latched request and registered pin/status outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
      op_r    <= OP_RD;
      addr_r  <= 8'h00;
      wdata_r <= 8'h00;
      pins_r  <= PINS_IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      rdata_r <= 8'h00;
      err_r   <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      op_r    <= op_nxt_s;
      addr_r  <= addr_nxt_s;
      wdata_r <= wdata_nxt_s;
      pins_r  <= phase_pins(state_nxt_s, op_nxt_s, addr_nxt_s, wdata_nxt_s);
      busy_r  <= (state_nxt_s != IDLE);
      done_r  <= (state_nxt_s == DONE);
      if (capture_s) rdata_r <= bus.bus_in;
      else           rdata_r <= rdata_r;
`ifdef RTC_VERIFY_EN
      if (accept_s)                           err_r <= 1'b0;
      else if (zero_s && state_r == V_D_HOLD) err_r <= (rdata_r != wdata_r);
      else                                    err_r <= err_r;
`else
      err_r <= 1'b0;
`endif
    end
  end

  assign bus.A_D     = pins_r.a_d;
  assign bus.CS      = pins_r.cs;
  assign bus.RD      = pins_r.rd;
  assign bus.WR      = pins_r.wr;
  assign bus.bus_oe  = pins_r.oe;
  assign bus.bus_out = pins_r.dout;
  assign bus.busy    = busy_r;
  assign bus.done    = done_r;
  assign bus.rdata   = rdata_r;
  assign bus.err     = err_r;

endmodule
